// File: rtl/i2c_pkg.sv
// Shared types and protocol constants for the single-master I2C initiator.
package i2c_pkg;

    typedef enum logic [3:0] {
        IDLE, START, ADDR, AACK, WDATA, WACK, RDATA, MNACK, STOP, DONE
    } state_t;

    localparam logic RW_READ        = 1'b1;
    localparam logic RW_WRITE       = 1'b0;
    localparam logic I2C_ACK        = 1'b0;
    localparam logic I2C_NACK       = 1'b1;
    localparam int   FRAME_QUARTERS = 4;

endpackage

// File: rtl/i2c_clk_gen.sv
// Quarter-period tick generator: CLK_DIV clk cycles per quarter, four quarters per bus frame.
module i2c_clk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       restart,
    output logic       tick,
    output logic [1:0] quarter
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] count;

    assign tick = (count == CW'(CLK_DIV - 1));

    // Held at zero while the master idles so every transaction starts on a Q0 boundary.
    always_ff @(posedge clk) begin
        if (reset || restart) begin
            count   <= '0;
            quarter <= '0;
        end else if (tick) begin
            count   <= '0;
            quarter <= quarter + 2'd1;
        end else begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/i2c_master.sv
// Single-byte I2C initiator: START, address, ACK, one data byte, (N)ACK, STOP.
module i2c_master
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       rw,
    input  logic [6:0] addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       scl,
    inout  wire        sda
);

    state_t     state, next_state;
    logic       tick, frame_end, sample_pt;
    logic [1:0] quarter;
    logic [2:0] bit_cnt;
    logic [6:0] addr_q;
    logic       rw_q;
    logic [7:0] wdata_q, rx_shift, tx_addr_byte;
    logic       sda_sample, sda_low;

    i2c_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
        .clk     (clk),
        .reset   (reset),
        .restart (state == IDLE),
        .tick    (tick),
        .quarter (quarter)
    );

    assign frame_end    = tick && (quarter == 2'(FRAME_QUARTERS - 1));
    assign sample_pt    = tick && (quarter == 2'd2);
    assign tx_addr_byte = {addr_q, rw_q};
    assign sda          = sda_low ? 1'b0 : 1'bz;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // NOTE: each combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:  if (start) next_state = START;
            START: if (frame_end) next_state = ADDR;
            ADDR:  if (frame_end && bit_cnt == 3'd0) next_state = AACK;
            AACK:  if (frame_end) begin
                       if (sda_sample == I2C_ACK)
                           next_state = (rw_q == RW_WRITE) ? WDATA : RDATA;
                       else
                           next_state = STOP;
                   end
            WDATA: if (frame_end && bit_cnt == 3'd0) next_state = WACK;
            WACK:  if (frame_end) next_state = STOP;
            RDATA: if (frame_end && bit_cnt == 3'd0) next_state = MNACK;
            MNACK: if (frame_end) next_state = STOP;
            STOP:  if (frame_end) next_state = DONE;
            DONE:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Bus pins decode straight from state and quarter, so SDA moves at the first cycle of Q0.
    always_comb begin
        scl     = 1'b1;
        sda_low = 1'b0;
        busy    = (state != IDLE) && (state != DONE);
        done    = (state == DONE);
        unique case (state)
            START: sda_low = quarter[1];
            ADDR: begin
                scl     = quarter[1];
                sda_low = ~tx_addr_byte[bit_cnt];
            end
            WDATA: begin
                scl     = quarter[1];
                sda_low = ~wdata_q[bit_cnt];
            end
            AACK, WACK, RDATA, MNACK: scl = quarter[1];
            STOP: begin
                scl     = quarter[1];
                sda_low = (quarter != 2'd3);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q     <= '0;
            rw_q       <= RW_WRITE;
            wdata_q    <= '0;
            bit_cnt    <= 3'd7;
            rx_shift   <= '0;
            sda_sample <= I2C_NACK;
            ack_err    <= 1'b0;
            rdata      <= '0;
        end else begin
            if (state == IDLE) begin
                bit_cnt <= 3'd7;
                if (start) begin
                    addr_q  <= addr;
                    rw_q    <= rw;
                    wdata_q <= wdata;
                    ack_err <= 1'b0;
                end
            end
            if (sample_pt) begin
                sda_sample <= sda;
                if (state == RDATA) rx_shift <= {rx_shift[6:0], sda};
            end
            // The 3-bit counter wraps 0 -> 7, ready for the next byte.
            if (frame_end && (state == ADDR || state == WDATA || state == RDATA))
                bit_cnt <= bit_cnt - 3'd1;
            if (frame_end && (state == AACK || state == WACK) && sda_sample == I2C_NACK)
                ack_err <= 1'b1;
            if (state == DONE && rw_q == RW_READ && !ack_err)
                rdata <= rx_shift;
        end
    end

endmodule

// File: tb/tb_i2c_master.sv
// Self-checking bench: bus-level slave/monitor model plus directed and random transactions.
module tb_i2c_master;

    localparam int CD = 4;

    typedef struct packed {
        logic [4:0]  nbits;
        logic [17:0] bits;
    } bus_rec_t;

    logic       clk, reset, start, rw;
    logic [6:0] addr;
    logic [7:0] wdata, rdata;
    logic       busy, done, ack_err, scl;
    wire        sda;

    logic       slave_low;
    logic [6:0] slave_addr;
    logic [7:0] slave_data;
    logic [7:0] model_rdata;
    bus_rec_t   bus_q[$];

    int checks   = 0;
    int failures = 0;

    i2c_master #(.CLK_DIV(CD)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .rw      (rw),
        .addr    (addr),
        .wdata   (wdata),
        .rdata   (rdata),
        .busy    (busy),
        .done    (done),
        .ack_err (ack_err),
        .scl     (scl),
        .sda     (sda)
    );

    pullup (sda);
    assign sda = slave_low ? 1'b0 : 1'bz;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Bus monitor and slave: decodes START/bits/STOP from the wires, answers like a real slave.
    int          mcyc = 0, last_rise = -1, last_fall = -1, nbits = 0;
    logic        prev_scl, prev_sda, cur_scl, cur_sda;
    logic        mon_valid = 1'b0, in_txn = 1'b0, matched = 1'b0, is_read = 1'b0, drive;
    logic [17:0] bits;

    always @(negedge clk) begin
        cur_scl = scl;
        cur_sda = sda;
        mcyc++;
        if (reset) begin
            mon_valid = 1'b0;
            in_txn    = 1'b0;
            last_rise = -1;
            last_fall = -1;
            slave_low <= 1'b0;
        end else if (!mon_valid) begin
            mon_valid = 1'b1;
        end else begin
            if (prev_scl && cur_scl && prev_sda != cur_sda) begin
                check("sda_change_scl_high", (!cur_sda && !in_txn) || (cur_sda && in_txn), 1'b1);
                if (!cur_sda && !in_txn) begin
                    in_txn    = 1'b1;
                    nbits     = 0;
                    bits      = '0;
                    matched   = 1'b0;
                    last_rise = -1;
                    last_fall = -1;
                end else if (cur_sda && in_txn) begin
                    in_txn = 1'b0;
                    bus_q.push_back('{nbits: 5'(nbits), bits: bits});
                end
            end
            if (!prev_scl && cur_scl) begin
                if (last_fall >= 0) check("scl_low_len", mcyc - last_fall, 2 * CD);
                last_rise = mcyc;
                last_fall = -1;
            end
            if (prev_scl && !cur_scl) begin
                if (last_rise >= 0) begin
                    check("scl_high_len", mcyc - last_rise, 2 * CD);
                    if (in_txn) begin
                        bits = {bits[16:0], prev_sda};
                        nbits++;
                        if (nbits == 8) begin
                            matched = (bits[7:1] == slave_addr);
                            is_read = bits[0];
                        end
                        drive = 1'b0;
                        if (matched) begin
                            if (nbits == 8) drive = 1'b1;
                            else if (is_read && nbits >= 9 && nbits <= 16) drive = !slave_data[16 - nbits];
                            else if (!is_read && nbits == 17) drive = 1'b1;
                        end
                        slave_low <= drive;
                    end
                end
                last_fall = mcyc;
                last_rise = -1;
            end
        end
        prev_scl = cur_scl;
        prev_sda = cur_sda;
    end

    // One transaction: the reference outcome comes from the protocol rules, not the DUT.
    task automatic run_txn(input logic r, input logic [6:0] a, input logic [7:0] wd,
                           input logic [6:0] s_addr, input logic [7:0] s_data,
                           input int intr_cyc, input logic poke_done);
        int          exp_lat, cyc, got;
        logic        ack, rd_stable;
        logic [7:0]  exp_rd, byte1;
        logic [17:0] exp_bits;
        int          exp_nbits;
        bus_rec_t    rec;

        ack       = (a == s_addr);
        exp_lat   = ack ? 80 * CD : 44 * CD;
        exp_rd    = (r && ack) ? s_data : model_rdata;
        byte1     = r ? s_data : wd;
        exp_nbits = ack ? 18 : 9;
        exp_bits  = ack ? {a, r, 1'b0, byte1, r} : {9'd0, a, r, 1'b1};
        slave_addr = s_addr;
        slave_data = s_data;

        @(negedge clk);
        rw = r; addr = a; wdata = wd; start = 1'b1;
        @(posedge clk);
        cyc = 0; got = -1; rd_stable = 1'b1;
        while (got < 0 && cyc <= exp_lat + 20) begin
            @(negedge clk);
            if (cyc == 0) begin
                check("busy_after_accept", busy, 1'b1);
                check("ack_err_cleared", ack_err, 1'b0);
            end
            if (done) begin
                got = cyc;
            end else begin
                if (rdata !== model_rdata) rd_stable = 1'b0;
                start = (cyc == intr_cyc);
                addr  = (cyc == intr_cyc) ? ~a : 7'($urandom);
                rw    = 1'($urandom);
                wdata = 8'($urandom);
                @(posedge clk);
                cyc++;
            end
        end
        check("done_cycle", got, exp_lat);
        check("ack_err", ack_err, !ack);
        check("busy_in_done", busy, 1'b0);
        start = poke_done;
        addr  = ~a;
        @(negedge clk);
        start = 1'b0;
        check("done_one_cycle", done, 1'b0);
        check("idle_after_done", busy, 1'b0);
        check("rdata", rdata, exp_rd);
        check("rdata_stable_during_txn", rd_stable, 1'b1);
        model_rdata = exp_rd;
        check("bus_rec_count", bus_q.size(), 1);
        if (bus_q.size() > 0) begin
            rec = bus_q.pop_front();
            check("bus_nbits", rec.nbits, exp_nbits);
            check("bus_bits", rec.bits, exp_bits);
        end
    endtask

    logic       r_r;
    logic [6:0] r_a, r_sa;
    logic [7:0] r_wd, r_sd;

    initial begin
        reset = 1'b1; start = 1'b0; rw = 1'b0; addr = '0; wdata = '0;
        slave_low = 1'b0; slave_addr = 7'h7F; slave_data = 8'h00; model_rdata = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_scl", scl, 1'b1);
        check("rst_sda", sda, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_ack_err", ack_err, 1'b0);
        check("rst_rdata", rdata, 8'h00);
        reset = 1'b0;

        run_txn(1'b1, 7'h2A, 8'h00, 7'h2A, 8'hA5, -1, 1'b0);
        run_txn(1'b0, 7'h11, 8'h3C, 7'h11, 8'h00, -1, 1'b1);
        run_txn(1'b1, 7'h2A, 8'h00, 7'h2B, 8'h77, -1, 1'b0);
        run_txn(1'b0, 7'h33, 8'hC3, 7'h33, 8'h00, 40, 1'b0);

        // Abort mid-ADDR: reset sampled at the edge ending cycle 60.
        slave_addr = 7'h2A; slave_data = 8'h96;
        @(negedge clk);
        rw = 1'b1; addr = 7'h2A; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (60) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        check("abort_scl", scl, 1'b1);
        check("abort_sda", sda, 1'b1);
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_ack_err", ack_err, 1'b0);
        check("abort_rdata", rdata, 8'h00);
        check("abort_no_stop", bus_q.size(), 0);
        model_rdata = 8'h00;
        @(posedge clk);
        #1 reset = 1'b0;
        run_txn(1'b1, 7'h2A, 8'h00, 7'h2A, 8'h96, -1, 1'b0);

        for (int i = 0; i < 6; i++) begin
            r_r  = 1'($urandom);
            r_a  = 7'($urandom);
            r_wd = 8'($urandom);
            r_sd = 8'($urandom);
            r_sa = ($urandom_range(0, 3) == 0) ? (r_a ^ 7'(1 << $urandom_range(0, 6))) : r_a;
            run_txn(r_r, r_a, r_wd, r_sa, r_sd, -1, 1'(i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/i2c_master.md
Name: i2c_master

Overview:
- Single-master I2C initiator that generates SCL and drives SDA open-drain. It is the bus-side counterpart of the on-chip measurement I2C slave.
- Executes one single-byte transaction per request:
  - Read: START, addr+R, slave ACK, 8 data bits from slave, master NACK, STOP.
  - Write: START, addr+W, slave ACK, 8 data bits to slave, slave ACK, STOP.
- Sits in the tester/reader logic and is clocked by the system clock. SCL is derived internally by division.

Parameters:
- CLK_DIV, 4, clk cycles per quarter SCL period. SCL period = 4*CLK_DIV clk cycles. Legal values ≥ 2.

Ports:
- clk  input  1  system clock. All logic is on its rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request strobe. Sampled only in IDLE.
- rw  input  1  1 = read, 0 = write. Latched with start.
- addr  input  7  target slave address. Latched with start.
- wdata  input  8  write byte. Latched with start.
- rdata  output  8  byte received by the last successful read.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse at transaction end.
- ack_err  output  1  set if the slave NACKed. Held until the next accepted start.
- scl  output  1  SCL, push-pull (single master on the bus).
- sda  inout  1  SDA, open-drain. Driven 0 or z; external pull-up.

Behaviour:
- Reset values (reset=1 at a clk edge), also applied when reset asserts mid-transaction:
  - scl=1, sda=z, busy=0, done=0, ack_err=0, rdata=0x00, state=IDLE.
  - Mid-transaction reset is an abrupt abort: no STOP is generated.
- Quarter-tick generator: counts 0..CLK_DIV-1, emitting a tick on wrap. Every bus "frame" is 4 quarters, Q0..Q3.
- Data/ACK frame:
  - Q0 and Q1: scl=0. SDA is updated at the first cycle of Q0.
  - Q2 and Q3: scl=1.
  - SDA is sampled on the last clk cycle of Q2.
- START frame:
  - Q0 and Q1: scl=1, sda=z.
  - Q2 and Q3: scl=1, sda=0.
- STOP frame:
  - Q0 and Q1: scl=0, sda=0.
  - Q2: scl=1, sda=0.
  - Q3: scl=1, sda=z.
- SDA may change while scl=1 only inside START and STOP frames.
- States:
  - IDLE: start=1 latches addr/rw/wdata, clears ack_err, sets busy, goes to START. Otherwise stays.
  - START → ADDR.
  - ADDR: 8 frames, MSB first: {addr[6:0], rw}. → AACK.
  - AACK: release SDA and sample.
    - Sample 0 → RDATA if rw=1, WDATA if rw=0.
    - Sample 1 → ack_err=1, then STOP.
  - WDATA: 8 frames, wdata MSB first. → WACK.
  - WACK: release SDA and sample. Sample 1 sets ack_err. → STOP in either case.
  - RDATA: SDA released for 8 frames. Sampled bits shift into a shift register, MSB first. → MNACK.
  - MNACK: SDA released (NACK = 1). → STOP.
  - STOP: after Q3 → DONE.
  - DONE: done=1 and busy=0 for one cycle. rdata ← shift register only if rw=1 and ack_err=0. → IDLE.
- Latency (start accepted at cycle 0; done asserts in cycle N):
  - Full transaction: 20 frames, N = 80*CLK_DIV. CLK_DIV=4 gives N=320.
  - Address NACK: 11 frames, N = 44*CLK_DIV. CLK_DIV=4 gives N=176.
- start while busy: ignored, with no effect on latched operands.
- start during the DONE cycle: ignored. It is accepted in IDLE only.
- rdata is unchanged by writes, by failed reads, and while a transaction is in progress.
- Inputs addr, rw and wdata may change freely after acceptance.
- Bus arbitration, clock stretching and repeated START are not supported.

Decomposition:
- Shared package i2c_pkg:
  - state enum (IDLE, START, ADDR, AACK, WDATA, WACK, RDATA, MNACK, STOP, DONE).
  - constants RW_READ=1, RW_WRITE=0, I2C_ACK=0, I2C_NACK=1, FRAME_QUARTERS=4.
- Sub-module i2c_clk_gen, parameterised by CLK_DIV. Outputs: quarter tick, quarter index[1:0]. Restarts at 0 when the master leaves IDLE.

Test Plan:
- Read, CLK_DIV=4: addr=0x2A, rw=1, slave model returns 0xA5.
  - Bus byte 0x55 is observed, then data 0xA5, then master NACK and STOP.
  - rdata=0xA5, ack_err=0, done pulse at cycle 320.
- Write: addr=0x11, rw=0, wdata=0x3C, slave ACKs both bytes.
  - Bus bytes 0x22 and 0x3C are observed, then STOP.
  - ack_err=0, done at cycle 320, rdata unchanged.
- Address NACK: slave at 0x2B, master addr=0x2A.
  - STOP follows the ACK frame, ack_err=1, done at cycle 176.
  - rdata keeps its previous value.
- Busy protection: second start with a different addr at cycle 40 is ignored.
  - Bus shows only the first address.
  - The next start after done is accepted and clears ack_err.
- Reset mid-ADDR: assert reset at cycle 60.
  - Next cycle: scl=1, sda=z, busy=0, done=0, ack_err=0.
  - A new read afterwards completes correctly.
- Protocol monitor across all tests: SDA never changes while scl=1 except in START (1→0) and STOP (0→1).
  - Every SCL high and low phase lasts exactly 2*CLK_DIV cycles.
